mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Single owner of the byte-wide RAM port.
- Arbitrates between two requesters:
  - instruction fetch (IF): always 4 bytes, read-only;
  - load/store stage (MEM): 1, 2 or 4 bytes, read or write.
- Serialises each request into byte accesses and assembles or splits 32-bit words little-endian.
- Returns a one-cycle done pulse with the result.
- Sits between the pipeline stages/icache fill path and the RAM.

Parameters:
- ADDR_W, 32, address width of requests and RAM.
- RAM_RD_LAT, 1, cycles from ram_a_o to valid ram_dout_i; only 1 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- rdy  in  1  global ready; 0 freezes all state.
- if_req_i  in  1  fetch request; held until if_done_o or flush.
- if_addr_i  in  32  fetch address.
- if_flush_i  in  1  branch taken; abort any IF transaction.
- if_done_o  out  1  one-cycle pulse, fetch complete.
- if_inst_o  out  32  fetched word; held until next if_done_o.
- mem_req_i  in  1  load/store request; held until mem_done_o.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_len_i  in  2  byte count minus 1: 0 = byte, 1 = half, 3 = word; 2 is illegal and treated as 3.
- mem_addr_i  in  32  data address.
- mem_wdata_i  in  32  store data, low bytes used.
- mem_done_o  out  1  one-cycle pulse, load/store complete.
- mem_rdata_o  out  32  load data, zero-filled above len; held until next mem_done_o.
- busy_o  out  1  1 while not IDLE; usable by the stall controller.
- ram_dout_i  in  8  RAM read byte.
- ram_din_o  out  8  RAM write byte.
- ram_a_o  out  32  RAM byte address.
- ram_wr_o  out  1  RAM write strobe.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE; all outputs and internal registers 0.
  - A transaction in flight is dropped with no done pulse.
- rdy = 0: no register updates.
  - ram_wr_o is gated to 0 combinationally.
  - Other outputs hold their values.
- All RAM outputs are registered. A read byte presented on ram_a_o in cycle t is valid on ram_dout_i in cycle t+1.
- States: IDLE, RD_IF, RD_MEM, WR_MEM.
- IDLE:
  - mem_req_i wins over if_req_i: MEM holds the older instruction.
  - On grant, latch addr, len and wdata. Set cnt = 0.
  - Drive ram_a_o = addr for the first byte. For a store, also drive ram_din_o = byte0 and ram_wr_o = 1.
  - Next state:
    - RD_IF for an IF grant;
    - RD_MEM for a MEM load;
    - WR_MEM for a MEM store.
  - An IF request with if_flush_i high in the same cycle is not granted.
- RD_* (N = len + 1 bytes):
  - Each cycle, capture ram_dout_i into data byte lane cnt and increment cnt.
  - While cnt < N-1, drive ram_a_o = addr + cnt + 1.
  - After capturing byte N-1:
    - move data to if_inst_o or mem_rdata_o (unused upper bytes = 0);
    - pulse the matching done for one cycle;
    - go to IDLE.
  - Latency: done is high N+1 cycles after the grant edge (word: 5).
- WR_MEM:
  - Byte i is written to addr + i as mem_wdata_i[8i+7:8i], one byte per cycle, ram_wr_o = 1.
  - After byte N-1: ram_wr_o = 0, mem_done_o pulses, go to IDLE.
  - Latency: done N+1 cycles after grant.
- Non-preemptive: a granted transaction completes before the other requester is served.
- Flush:
  - if_flush_i in RD_IF: abort at the next edge, go to IDLE, no if_done_o. if_inst_o is unchanged.
  - Flush does not affect RD_MEM or WR_MEM.
  - Flush in IDLE only suppresses an IF grant that cycle.
- Done and re-request:
  - The done cycle is always followed by IDLE, so back-to-back grants are at least one cycle apart.
  - Requesters must drop or update req in the cycle after done.
  - A req still high in IDLE is treated as a new request.
- Simultaneous mem_req_i and if_req_i in the done cycle of a MEM transaction: MEM is re-arbitrated first. There is no fairness guarantee; IF starves while MEM requests continuously.
- Address arithmetic wraps modulo 2^32.
- busy_o = (state != IDLE).

Decomposition:
- defines.v receives:
  - state encodings (IDLE, RD_IF, RD_MEM, WR_MEM);
  - length codes (LenByte = 2'b00, LenHalf = 2'b01, LenWord = 2'b11);
  - the byte bus width.
- No sub-module. Byte-lane assembly and the state machine fit in one module.

Test Plan:
- IF word fetch at 0x100, RAM bytes 13 05 00 00 → if_done_o 5 cycles after grant; if_inst_o = 0x00000513; ram_a_o = 0x100..0x103 in order.
- MEM store word 0xDEADBEEF at 0x1000 → ram_wr_o high 4 cycles; bytes EF, BE, AD, DE at 0x1000..0x1003; mem_done_o in cycle 5.
- MEM load half at 0x2002, RAM 34 12 → mem_rdata_o = 0x00001234; mem_done_o 3 cycles after grant.
- IF and MEM requests in the same cycle (MEM = byte load at 0x10) → MEM is served first (done after 2 cycles); IF is granted in the IDLE cycle after mem_done_o.
- if_flush_i during byte 2 of an IF fetch → no if_done_o; state returns to IDLE; the next IF request to the new address is fetched correctly.
- rst pulled to 0 mid-store → ram_wr_o = 0 immediately; all outputs 0. rdy = 0 mid-load for 3 cycles → done is delayed by exactly 3 cycles and the data is correct.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-serial RAM arbiter.
package mem_arbiter_pkg;

    // Arbiter states: idle, instruction read, data read, data write.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_IF  = 2'd1,
        RD_MEM = 2'd2,
        WR_MEM = 2'd3
    } state_t;

    // Length codes are "byte count minus one".
    localparam logic [1:0] LenByte = 2'b00;
    localparam logic [1:0] LenHalf = 2'b01;
    localparam logic [1:0] LenWord = 2'b11;

    // Width of the RAM data bus.
    localparam int BYTE_W = 8;

    // Code 2 is illegal and is widened to a full word.
    function automatic logic [1:0] norm_len(input logic [1:0] len);
        return (len == 2'b10) ? LenWord : len;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signal bundle for the memory arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    import mem_arbiter_pkg::*;

    // Instruction fetch port
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_flush_i;
    logic              if_done_o;
    logic [31:0]       if_inst_o;

    // Load/store port
    logic              mem_req_i;
    logic              mem_we_i;
    logic [1:0]        mem_len_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [31:0]       mem_wdata_i;
    logic              mem_done_o;
    logic [31:0]       mem_rdata_o;

    // Status
    logic              busy_o;

    // Byte-wide RAM port
    logic [BYTE_W-1:0] ram_dout_i;
    logic [BYTE_W-1:0] ram_din_o;
    logic [ADDR_W-1:0] ram_a_o;
    logic              ram_wr_o;

    // Arbiter side
    modport slave (
        input  if_req_i, if_addr_i, if_flush_i,
        output if_done_o, if_inst_o,
        input  mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
        output mem_done_o, mem_rdata_o,
        output busy_o,
        input  ram_dout_i,
        output ram_din_o, ram_a_o, ram_wr_o
    );

    // Requester / RAM model side
    modport master (
        output if_req_i, if_addr_i, if_flush_i,
        input  if_done_o, if_inst_o,
        output mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
        input  mem_done_o, mem_rdata_o,
        input  busy_o,
        output ram_dout_i,
        input  ram_din_o, ram_a_o, ram_wr_o
    );

endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter owning the RAM port: serves load/store (priority)
// and instruction fetch, assembling/splitting little-endian words.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int RAM_RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    mem_arbiter_if.slave bus
);

    state_t             r_state,     w_state;
    logic [ADDR_W-1:0]  r_addr,      w_addr;
    logic [1:0]         r_len,       w_len;
    logic [1:0]         r_cnt,       w_cnt;
    logic [31:0]        r_wdata,     w_wdata;
    logic [31:0]        r_data,      w_data;
    logic [31:0]        r_if_inst,   w_if_inst;
    logic [31:0]        r_mem_rdata, w_mem_rdata;
    logic               r_if_done,   w_if_done;
    logic               r_mem_done,  w_mem_done;
    logic [ADDR_W-1:0]  r_ram_a,     w_ram_a;
    logic [BYTE_W-1:0]  r_ram_din,   w_ram_din;
    logic               r_ram_wr,    w_ram_wr;

    logic [31:0]        w_data_cap;
    logic [1:0]         w_cnt_inc;
    logic               w_grant_ok;

    // Current read byte dropped into lane cnt of the assembly word.
    always_comb begin
        w_data_cap = r_data;
        w_data_cap[{r_cnt, 3'b000} +: BYTE_W] = bus.ram_dout_i;
    end

    assign w_cnt_inc = r_cnt + 2'd1;
    // The cycle carrying a done pulse never grants, so a requester still
    // holding req in that cycle is not served twice.
    assign w_grant_ok = !(r_if_done || r_mem_done);

    // Next-state and next-output logic for the arbiter FSM.
    always_comb begin
        w_state     = r_state;
        w_addr      = r_addr;
        w_len       = r_len;
        w_cnt       = r_cnt;
        w_wdata     = r_wdata;
        w_data      = r_data;
        w_if_inst   = r_if_inst;
        w_mem_rdata = r_mem_rdata;
        w_if_done   = 1'b0;
        w_mem_done  = 1'b0;
        w_ram_a     = r_ram_a;
        w_ram_din   = r_ram_din;
        w_ram_wr    = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_grant_ok && bus.mem_req_i) begin
                    w_addr  = bus.mem_addr_i;
                    w_len   = norm_len(bus.mem_len_i);
                    w_wdata = bus.mem_wdata_i;
                    w_cnt   = 2'd0;
                    w_data  = '0;
                    w_ram_a = bus.mem_addr_i;
                    if (bus.mem_we_i) begin
                        w_ram_din = bus.mem_wdata_i[BYTE_W-1:0];
                        w_ram_wr  = 1'b1;
                        w_state   = WR_MEM;
                    end else begin
                        w_state   = RD_MEM;
                    end
                end else if (w_grant_ok && bus.if_req_i && !bus.if_flush_i) begin
                    w_addr  = bus.if_addr_i;
                    w_len   = LenWord;
                    w_cnt   = 2'd0;
                    w_data  = '0;
                    w_ram_a = bus.if_addr_i;
                    w_state = RD_IF;
                end
            end

            RD_IF, RD_MEM: begin
                if (r_state == RD_IF && bus.if_flush_i) begin
                    w_state = IDLE;
                end else begin
                    w_data = w_data_cap;
                    if (r_cnt == r_len) begin
                        w_state = IDLE;
                        if (r_state == RD_IF) begin
                            w_if_inst = w_data_cap;
                            w_if_done = 1'b1;
                        end else begin
                            w_mem_rdata = w_data_cap;
                            w_mem_done  = 1'b1;
                        end
                    end else begin
                        w_cnt   = w_cnt_inc;
                        // Address runs one read latency ahead of capture.
                        w_ram_a = r_addr + ADDR_W'(r_cnt) + ADDR_W'(RAM_RD_LAT);
                    end
                end
            end

            WR_MEM: begin
                if (r_cnt == r_len) begin
                    w_mem_done = 1'b1;
                    w_state    = IDLE;
                end else begin
                    w_cnt     = w_cnt_inc;
                    w_ram_a   = r_addr + ADDR_W'(w_cnt_inc);
                    w_ram_din = r_wdata[{w_cnt_inc, 3'b000} +: BYTE_W];
                    w_ram_wr  = 1'b1;
                end
            end

            default: w_state = IDLE;
        endcase
    end

    // State and registered outputs; rdy low freezes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_len       <= 2'd0;
            r_cnt       <= 2'd0;
            r_wdata     <= '0;
            r_data      <= '0;
            r_if_inst   <= '0;
            r_mem_rdata <= '0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            r_ram_a     <= '0;
            r_ram_din   <= '0;
            r_ram_wr    <= 1'b0;
        end else if (rdy) begin
            r_state     <= w_state;
            r_addr      <= w_addr;
            r_len       <= w_len;
            r_cnt       <= w_cnt;
            r_wdata     <= w_wdata;
            r_data      <= w_data;
            r_if_inst   <= w_if_inst;
            r_mem_rdata <= w_mem_rdata;
            r_if_done   <= w_if_done;
            r_mem_done  <= w_mem_done;
            r_ram_a     <= w_ram_a;
            r_ram_din   <= w_ram_din;
            r_ram_wr    <= w_ram_wr;
        end
    end

    assign bus.if_done_o   = r_if_done;
    assign bus.if_inst_o   = r_if_inst;
    assign bus.mem_done_o  = r_mem_done;
    assign bus.mem_rdata_o = r_mem_rdata;
    assign bus.busy_o      = (r_state != IDLE);
    assign bus.ram_a_o     = r_ram_a;
    assign bus.ram_din_o   = r_ram_din;
    // A frozen write cycle must not repeat the write into the RAM.
    assign bus.ram_wr_o    = r_ram_wr & rdy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: RAM model, done/write scoreboard.
module tb_mem_arbiter;

    typedef struct {
        logic [31:0] data;
        int unsigned cyc;
        bit          chk_data;
    } done_exp_t;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .RAM_RD_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    // Asynchronous-read RAM behind the registered address.
    logic [7:0] ram_mem [0:65535];
    assign bus.ram_dout_i = ram_mem[bus.ram_a_o[15:0]];

    done_exp_t   exp_if_q[$];
    done_exp_t   exp_mem_q[$];
    wr_exp_t     exp_wr_q[$];
    int unsigned cyc    = 0;
    int          errors = 0;
    int          checks = 0;

    // Advance one cycle, sample at the falling edge, drain the scoreboard.
    task automatic tick();
        done_exp_t e;
        wr_exp_t   w;
        @(negedge clk);
        cyc++;
        if (bus.ram_wr_o) begin
            checks++;
            if (exp_wr_q.size() == 0) begin
                errors++;
                $display("FAIL ram_wr unexpected: a=%h d=%h, required no write", bus.ram_a_o, bus.ram_din_o);
            end else begin
                w = exp_wr_q.pop_front();
                if (bus.ram_a_o !== w.a || bus.ram_din_o !== w.d) begin
                    errors++;
                    $display("FAIL ram_wr: a=%h d=%h, required a=%h d=%h", bus.ram_a_o, bus.ram_din_o, w.a, w.d);
                end
            end
        end
        if (bus.if_done_o) begin
            checks++;
            if (exp_if_q.size() == 0) begin
                errors++;
                $display("FAIL if_done unexpected: inst=%h at cycle %0d, required no pulse", bus.if_inst_o, cyc);
            end else begin
                e = exp_if_q.pop_front();
                if (bus.if_inst_o !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL if_done: inst=%h cycle=%0d, required inst=%h cycle=%0d", bus.if_inst_o, cyc, e.data, e.cyc);
                end
            end
        end
        if (bus.mem_done_o) begin
            checks++;
            if (exp_mem_q.size() == 0) begin
                errors++;
                $display("FAIL mem_done unexpected: rdata=%h at cycle %0d, required no pulse", bus.mem_rdata_o, cyc);
            end else begin
                e = exp_mem_q.pop_front();
                if ((e.chk_data && bus.mem_rdata_o !== e.data) || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL mem_done: rdata=%h cycle=%0d, required rdata=%h cycle=%0d", bus.mem_rdata_o, cyc, e.data, e.cyc);
                end
            end
        end
    endtask

    // Tick until the selected done output is seen or the budget runs out.
    task automatic wait_done(input bit is_mem, input int budget, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (is_mem ? bus.mem_done_o : bus.if_done_o) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.if_req_i    = 1'b0;
        bus.if_addr_i   = '0;
        bus.if_flush_i  = 1'b0;
        bus.mem_req_i   = 1'b0;
        bus.mem_we_i    = 1'b0;
        bus.mem_len_i   = 2'd0;
        bus.mem_addr_i  = '0;
        bus.mem_wdata_i = '0;
        rst = 1'b0;
        rdy = 1'b1;
        repeat (2) tick();
        checks++; if (bus.if_done_o !== 1'b0)  begin errors++; $display("FAIL reset if_done: got %b, required 0", bus.if_done_o); end
        checks++; if (bus.mem_done_o !== 1'b0) begin errors++; $display("FAIL reset mem_done: got %b, required 0", bus.mem_done_o); end
        checks++; if (bus.if_inst_o !== 32'h0) begin errors++; $display("FAIL reset if_inst: got %h, required 0", bus.if_inst_o); end
        checks++; if (bus.mem_rdata_o !== 32'h0) begin errors++; $display("FAIL reset mem_rdata: got %h, required 0", bus.mem_rdata_o); end
        checks++; if (bus.busy_o !== 1'b0)     begin errors++; $display("FAIL reset busy: got %b, required 0", bus.busy_o); end
        checks++; if (bus.ram_a_o !== 32'h0)   begin errors++; $display("FAIL reset ram_a: got %h, required 0", bus.ram_a_o); end
        checks++; if (bus.ram_wr_o !== 1'b0)   begin errors++; $display("FAIL reset ram_wr: got %b, required 0", bus.ram_wr_o); end
        rst = 1'b1;
        tick();
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL post-reset busy: got %b, required 0", bus.busy_o); end
    endtask

    task automatic test_if_fetch();
        bit seen;
        ram_mem[16'h0100] = 8'h13; ram_mem[16'h0101] = 8'h05;
        ram_mem[16'h0102] = 8'h00; ram_mem[16'h0103] = 8'h00;
        bus.if_addr_i = 32'h0000_0100;
        bus.if_req_i  = 1'b1;
        exp_if_q.push_back('{data: 32'h0000_0513, cyc: cyc + 5, chk_data: 1'b1});
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.ram_a_o !== 32'h0000_0100 + 32'(i)) begin
                errors++;
                $display("FAIL if_fetch ram_a[%0d]: got %h, required %h", i, bus.ram_a_o, 32'h0000_0100 + 32'(i));
            end
        end
        wait_done(1'b0, 10, seen);
        checks++; if (!seen) begin errors++; $display("FAIL if_fetch timeout: done=0, required 1"); end
        bus.if_req_i = 1'b0;
        tick();
    endtask

    task automatic test_store_word();
        bit seen;
        bus.mem_addr_i  = 32'h0000_1000;
        bus.mem_wdata_i = 32'hDEAD_BEEF;
        bus.mem_len_i   = 2'b11;
        bus.mem_we_i    = 1'b1;
        bus.mem_req_i   = 1'b1;
        exp_wr_q.push_back('{a: 32'h1000, d: 8'hEF});
        exp_wr_q.push_back('{a: 32'h1001, d: 8'hBE});
        exp_wr_q.push_back('{a: 32'h1002, d: 8'hAD});
        exp_wr_q.push_back('{a: 32'h1003, d: 8'hDE});
        exp_mem_q.push_back('{data: 32'h0, cyc: cyc + 5, chk_data: 1'b0});
        wait_done(1'b1, 10, seen);
        checks++; if (!seen) begin errors++; $display("FAIL store timeout: done=0, required 1"); end
        checks++; if (exp_wr_q.size() != 0) begin errors++; $display("FAIL store writes: %0d left, required 0", exp_wr_q.size()); end
        checks++; if (bus.ram_wr_o !== 1'b0) begin errors++; $display("FAIL store wr at done: got %b, required 0", bus.ram_wr_o); end
        bus.mem_req_i = 1'b0;
        bus.mem_we_i  = 1'b0;
        tick();
    endtask

    task automatic test_load_half();
        bit seen;
        ram_mem[16'h2002] = 8'h34; ram_mem[16'h2003] = 8'h12;
        bus.mem_addr_i = 32'h0000_2002;
        bus.mem_len_i  = 2'b01;
        bus.mem_we_i   = 1'b0;
        bus.mem_req_i  = 1'b1;
        exp_mem_q.push_back('{data: 32'h0000_1234, cyc: cyc + 3, chk_data: 1'b1});
        wait_done(1'b1, 10, seen);
        checks++; if (!seen) begin errors++; $display("FAIL load_half timeout: done=0, required 1"); end
        bus.mem_req_i = 1'b0;
        tick();
    endtask

    task automatic test_arbitration();
        bit seen;
        ram_mem[16'h0010] = 8'hA5;
        bus.mem_addr_i = 32'h0000_0010;
        bus.mem_len_i  = 2'b00;
        bus.mem_we_i   = 1'b0;
        bus.mem_req_i  = 1'b1;
        bus.if_addr_i  = 32'h0000_0100;
        bus.if_req_i   = 1'b1;
        exp_mem_q.push_back('{data: 32'h0000_00A5, cyc: cyc + 2, chk_data: 1'b1});
        exp_if_q.push_back('{data: 32'h0000_0513, cyc: cyc + 8, chk_data: 1'b1});
        tick();
        checks++; if (bus.ram_a_o !== 32'h0000_0010) begin errors++; $display("FAIL arb first grant ram_a: got %h, required 00000010", bus.ram_a_o); end
        checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL arb busy: got %b, required 1", bus.busy_o); end
        wait_done(1'b1, 10, seen);
        checks++; if (!seen) begin errors++; $display("FAIL arb mem timeout: done=0, required 1"); end
        bus.mem_req_i = 1'b0;
        wait_done(1'b0, 12, seen);
        checks++; if (!seen) begin errors++; $display("FAIL arb if timeout: done=0, required 1"); end
        bus.if_req_i = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        bit seen;
        ram_mem[16'h0200] = 8'h11; ram_mem[16'h0201] = 8'h22;
        ram_mem[16'h0202] = 8'h33; ram_mem[16'h0203] = 8'h44;
        ram_mem[16'h0300] = 8'h93; ram_mem[16'h0301] = 8'h00;
        ram_mem[16'h0302] = 8'h10; ram_mem[16'h0303] = 8'h00;
        bus.if_addr_i = 32'h0000_0200;
        bus.if_req_i  = 1'b1;
        repeat (3) tick();
        bus.if_flush_i = 1'b1;
        tick();
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL flush busy: got %b, required 0", bus.busy_o); end
        checks++; if (bus.if_inst_o !== 32'h0000_0513) begin errors++; $display("FAIL flush if_inst: got %h, required 00000513", bus.if_inst_o); end
        bus.if_flush_i = 1'b0;
        bus.if_addr_i  = 32'h0000_0300;
        exp_if_q.push_back('{data: 32'h0010_0093, cyc: cyc + 5, chk_data: 1'b1});
        wait_done(1'b0, 10, seen);
        checks++; if (!seen) begin errors++; $display("FAIL flush refetch timeout: done=0, required 1"); end
        bus.if_req_i = 1'b0;
        tick();
    endtask

    task automatic test_rdy_stall();
        bit seen;
        ram_mem[16'h3000] = 8'h78; ram_mem[16'h3001] = 8'h56;
        ram_mem[16'h3002] = 8'h34; ram_mem[16'h3003] = 8'h12;
        bus.mem_addr_i = 32'h0000_3000;
        bus.mem_len_i  = 2'b10;
        bus.mem_we_i   = 1'b0;
        bus.mem_req_i  = 1'b1;
        exp_mem_q.push_back('{data: 32'h1234_5678, cyc: cyc + 8, chk_data: 1'b1});
        repeat (2) tick();
        rdy = 1'b0;
        tick();
        checks++; if (bus.ram_a_o !== 32'h0000_3001) begin errors++; $display("FAIL stall ram_a: got %h, required 00003001", bus.ram_a_o); end
        repeat (2) tick();
        checks++; if (bus.ram_a_o !== 32'h0000_3001) begin errors++; $display("FAIL stall hold ram_a: got %h, required 00003001", bus.ram_a_o); end
        rdy = 1'b1;
        wait_done(1'b1, 12, seen);
        checks++; if (!seen) begin errors++; $display("FAIL stall timeout: done=0, required 1"); end
        bus.mem_req_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_store();
        bus.mem_addr_i  = 32'h0000_4000;
        bus.mem_wdata_i = 32'h1122_3344;
        bus.mem_len_i   = 2'b11;
        bus.mem_we_i    = 1'b1;
        bus.mem_req_i   = 1'b1;
        exp_wr_q.push_back('{a: 32'h4000, d: 8'h44});
        exp_wr_q.push_back('{a: 32'h4001, d: 8'h33});
        exp_wr_q.push_back('{a: 32'h4002, d: 8'h22});
        exp_wr_q.push_back('{a: 32'h4003, d: 8'h11});
        repeat (2) tick();
        checks++; if (bus.ram_wr_o !== 1'b1) begin errors++; $display("FAIL mid-store wr: got %b, required 1", bus.ram_wr_o); end
        rst = 1'b0;
        #1;
        checks++; if (bus.ram_wr_o !== 1'b0)  begin errors++; $display("FAIL rst ram_wr: got %b, required 0", bus.ram_wr_o); end
        checks++; if (bus.busy_o !== 1'b0)    begin errors++; $display("FAIL rst busy: got %b, required 0", bus.busy_o); end
        checks++; if (bus.ram_a_o !== 32'h0)  begin errors++; $display("FAIL rst ram_a: got %h, required 0", bus.ram_a_o); end
        checks++; if (bus.ram_din_o !== 8'h0) begin errors++; $display("FAIL rst ram_din: got %h, required 0", bus.ram_din_o); end
        checks++; if (bus.if_inst_o !== 32'h0) begin errors++; $display("FAIL rst if_inst: got %h, required 0", bus.if_inst_o); end
        checks++; if (bus.mem_rdata_o !== 32'h0) begin errors++; $display("FAIL rst mem_rdata: got %h, required 0", bus.mem_rdata_o); end
        exp_wr_q.delete();
        bus.mem_req_i = 1'b0;
        bus.mem_we_i  = 1'b0;
        tick();
        rst = 1'b1;
        repeat (4) tick();
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL after rst busy: got %b, required 0", bus.busy_o); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram_mem[i] = 8'h00;
        test_reset();
        test_if_fetch();
        test_store_word();
        test_load_half();
        test_arbitration();
        test_flush();
        test_rdy_stall();
        test_reset_mid_store();
        checks++;
        if (exp_if_q.size() != 0 || exp_mem_q.size() != 0) begin
            errors++;
            $display("FAIL pending done: if=%0d mem=%0d, required 0 0", exp_if_q.size(), exp_mem_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
